// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with a small input FIFO.
//   Bytes arrive on an AXI-stream style handshake, queue in the FIFO and are
//   serialised as start bit, 8 data bits LSB first and stop bit. Back-to-back
//   frames follow each other with no idle gap.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   tvalid      - input byte valid
//   tready      - byte can be accepted this cycle (FIFO not full)
//   tdata[7:0]  - input byte
//   tx          - serial line, idle high, driven from a flop
//   busy        - frame on the line or bytes still queued
//   fifo_level  - FIFO occupancy, 0..fifo_depth
module uart_tx #(
  parameter int cycles_per_bit = 434,
  parameter int fifo_depth     = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            tvalid,
  output logic                            tready,
  input  logic [7:0]                      tdata,
  output logic                            tx,
  output logic                            busy,
  output logic [$clog2(fifo_depth+1)-1:0] fifo_level
);

  localparam int CNT_W = $clog2(cycles_per_bit);
  localparam int AW    = $clog2(fifo_depth);
  localparam int LW    = $clog2(fifo_depth + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(cycles_per_bit - 1);
  localparam logic [LW-1:0]    LVL_FULL = LW'(fifo_depth);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // ---------------- input FIFO ----------------
  logic [7:0]    mem [fifo_depth];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level, level_n;
  logic          not_full_q;
  logic          push, pop;

  // not_full_q is registered; rst gates it so tready is low for the whole
  // reset window, and the cleared flop keeps it low one cycle past it.
  assign tready = !rst && not_full_q;
  assign push   = tvalid && tready;

  always_comb begin
    level_n = level;
    if (push && !pop)      level_n = level + 1'b1;
    else if (!push && pop) level_n = level - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      not_full_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level      <= level_n;
      not_full_q <= (level_n != LVL_FULL);
    end
  end

  // ---------------- serialiser FSM ----------------
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       idx, idx_n;
  logic [7:0]       shift, shift_n;
  logic             tx_q, tx_n;
  logic             cnt_last, have_byte;

  assign cnt_last  = (cnt == CNT_LAST);
  assign have_byte = (level != '0);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (have_byte) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          cnt_n   = '0;
          state_n = START;
        end
      end
      START: begin
        if (cnt_last) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt_last) begin
          cnt_n = '0;
          if (idx == 3'd7) state_n = STOP;
          else             idx_n   = idx + 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt_last) begin
          cnt_n = '0;
          // Chain straight into the next start bit when a byte is waiting.
          if (have_byte) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Line level is computed from the next state so the flop output changes
    // on the same edge as the state does.
    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[idx_n];
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      tx_q  <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shift <= shift_n;
      tx_q  <= tx_n;
    end
  end

  assign tx         = tx_q;
  assign busy       = (state != IDLE) || have_byte;
  assign fifo_level = level;

endmodule
